// File: rtl/fft_pkg.sv
// Shared constants and FSM state type for the FFT power accumulator.
package fft_pkg;

  localparam int FRAME_LEN = 512;
  localparam int ADDR_W    = 9;
  localparam int DATA_W    = 18;
  localparam int CNT_W     = 10;
  localparam int ACC_W     = 48;

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_READ,
    ST_DRAIN,
    ST_DUMP
  } fft_state_e;

endpackage

// File: rtl/fft_acc_ram.sv
// Simple dual-port accumulation RAM: one write port, one read port with a
// registered output that holds its value while rd_en_i is low.
module fft_acc_ram #(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 9,
  parameter int DATA_W = 48
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // NOTE: the array has no reset so it maps onto block RAM; the first frame
  // of every integration overwrites each entry before it is read back.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fft_power_accum.sv
// Integrates per-bin FFT power (re^2 + im^2) over acc_len frames and streams the
// spectrum out. Define FFT_PWR_SAT_EN for saturating accumulation with sat_flag.
module fft_power_accum #(
  parameter int FRAME_LEN = fft_pkg::FRAME_LEN,
  parameter int ADDR_W    = fft_pkg::ADDR_W,
  parameter int DATA_W    = fft_pkg::DATA_W,
  parameter int CNT_W     = fft_pkg::CNT_W,
  parameter int ACC_W     = fft_pkg::ACC_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2*DATA_W-1:0] fifo_dout,
  input  logic                fifo_empty,
  input  logic [CNT_W-1:0]    fifo_dcount,
  output logic                fifo_rd_en,
  input  logic [15:0]         acc_len,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ADDR_W-1:0]   out_bin,
  output logic [ACC_W-1:0]    out_data,
  output logic                out_last,
  output logic                busy,
  output logic                sat_flag
);

  import fft_pkg::*;

  localparam int SQ_W = 2 * DATA_W;
  localparam int P_W  = SQ_W + 1;

  fft_state_e        state_q, state_d;
  logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [1:0]        drain_cnt_q, drain_cnt_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic [15:0]       len_q, len_d;
  logic              rd_issue;
  logic              dump_done;

  // ---------------------------------------------------------------- control
  // NOTE: every always_comb output gets a default first so no latch can form.
  always_comb begin
    state_d     = state_q;
    rd_cnt_d    = rd_cnt_q;
    drain_cnt_d = drain_cnt_q;
    frame_cnt_d = frame_cnt_q;
    len_d       = len_q;
    rd_issue    = 1'b0;
    unique case (state_q)
      ST_WAIT: begin
        if (frame_cnt_q == '0) begin
          len_d = (acc_len == '0) ? 16'd1 : acc_len;
        end
        if (fifo_dcount >= CNT_W'(FRAME_LEN - 1)) begin
          state_d  = ST_READ;
          rd_cnt_d = '0;
        end
      end
      ST_READ: begin
        rd_issue = !fifo_empty;
        if (rd_issue) begin
          rd_cnt_d = rd_cnt_q + 1'b1;
          if (rd_cnt_q == ADDR_W'(FRAME_LEN - 1)) begin
            state_d     = ST_DRAIN;
            drain_cnt_d = '0;
          end
        end
      end
      ST_DRAIN: begin
        drain_cnt_d = drain_cnt_q + 2'd1;
        if (drain_cnt_q == 2'd3) begin
          if (frame_cnt_q + 16'd1 == len_q) begin
            frame_cnt_d = '0;
            state_d     = ST_DUMP;
          end else begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            state_d     = ST_WAIT;
          end
        end
      end
      ST_DUMP: begin
        if (dump_done) begin
          state_d = ST_WAIT;
        end
      end
      default: state_d = ST_WAIT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_WAIT;
      rd_cnt_q    <= '0;
      drain_cnt_q <= '0;
      frame_cnt_q <= '0;
      len_q       <= 16'd1;
    end else begin
      state_q     <= state_d;
      rd_cnt_q    <= rd_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      len_q       <= len_d;
    end
  end

  assign fifo_rd_en = rd_issue;
  assign busy       = (state_q != ST_WAIT);

  // --------------------------------------------------------------- datapath
  // a: FIFO data on the bus, b: sampled, c: squares, d: power + RAM data.
  logic                     v_a_q, v_b_q, v_c_q, v_d_q;
  logic [ADDR_W-1:0]        bin_a_q, bin_b_q, bin_c_q, bin_d_q;
  logic signed [DATA_W-1:0] re_q, im_q;
  logic signed [SQ_W-1:0]   re_ext, im_ext;
  logic [SQ_W-1:0]          sq_re_q, sq_im_q;
  logic [P_W-1:0]           p_q;

  assign re_ext = {{DATA_W{re_q[DATA_W-1]}}, re_q};
  assign im_ext = {{DATA_W{im_q[DATA_W-1]}}, im_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      v_a_q <= 1'b0;
      v_b_q <= 1'b0;
      v_c_q <= 1'b0;
      v_d_q <= 1'b0;
    end else begin
      v_a_q <= rd_issue;
      v_b_q <= v_a_q;
      v_c_q <= v_b_q;
      v_d_q <= v_c_q;
    end
  end

  // Payload registers are qualified by the valid chain and need no reset.
  always_ff @(posedge clk) begin
    bin_a_q <= rd_cnt_q;
    bin_b_q <= bin_a_q;
    bin_c_q <= bin_b_q;
    bin_d_q <= bin_c_q;
    re_q    <= fifo_dout[2*DATA_W-1:DATA_W];
    im_q    <= fifo_dout[DATA_W-1:0];
    sq_re_q <= re_ext * re_ext;
    sq_im_q <= im_ext * im_ext;
    p_q     <= P_W'(sq_re_q) + P_W'(sq_im_q);
  end

  // ------------------------------------------------------------- accumulate
  logic [ACC_W-1:0]  ram_rd_data;
  logic [ACC_W-1:0]  acc_base;
  logic [ACC_W-1:0]  acc_new;
  logic              ram_rd_en;
  logic [ADDR_W-1:0] ram_rd_addr;

  assign acc_base = (frame_cnt_q == '0) ? '0 : ram_rd_data;

`ifdef FFT_PWR_SAT_EN
  localparam int SUM_W = ((ACC_W > P_W) ? ACC_W : P_W) + 1;
  logic [SUM_W-1:0] sum_wide;
  logic             sat_hit;
  logic             sat_flag_q;

  always_comb begin
    sum_wide = SUM_W'(acc_base) + SUM_W'(p_q);
    sat_hit  = |sum_wide[SUM_W-1:ACC_W];
    acc_new  = sat_hit ? '1 : sum_wide[ACC_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sat_flag_q <= 1'b0;
    end else if (v_d_q && sat_hit) begin
      sat_flag_q <= 1'b1;
    end
  end

  assign sat_flag = sat_flag_q;
`else
  assign acc_new  = acc_base + ACC_W'(p_q);
  assign sat_flag = 1'b0;
`endif

  // ------------------------------------------------------------------- dump
  // The RAM output register holds while its read is disabled, so it doubles
  // as the one-deep skid stage behind the output register.
  logic              dumping;
  logic [ADDR_W:0]   dump_issue_q;
  logic [ADDR_W-1:0] dump_bin_q;
  logic              rv_q;
  logic              load_out;
  logic              dump_rd;
  logic              out_valid_q;
  logic [ADDR_W-1:0] out_bin_q;
  logic [ACC_W-1:0]  out_data_q;
  logic              out_last_q;

  assign dumping   = (state_q == ST_DUMP);
  assign load_out  = rv_q && (!out_valid_q || out_ready);
  assign dump_rd   = dumping && !dump_issue_q[ADDR_W] && (!rv_q || load_out);
  assign dump_done = out_valid_q && out_ready && out_last_q;

  always_ff @(posedge clk) begin
    if (rst || !dumping) begin
      dump_issue_q <= '0;
      rv_q         <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      if (dump_rd) begin
        dump_issue_q <= dump_issue_q + 1'b1;
        rv_q         <= 1'b1;
      end else if (load_out) begin
        rv_q <= 1'b0;
      end
      if (load_out) begin
        out_valid_q <= 1'b1;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (dump_rd) begin
      dump_bin_q <= dump_issue_q[ADDR_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_bin_q  <= '0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
    end else if (load_out) begin
      out_bin_q  <= dump_bin_q;
      out_data_q <= ram_rd_data;
      out_last_q <= (dump_bin_q == ADDR_W'(FRAME_LEN - 1));
    end
  end

  assign out_valid = out_valid_q;
  assign out_bin   = out_bin_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

  // The read port serves the accumulate pipeline, or the dump when idle.
  assign ram_rd_en   = dumping ? dump_rd : v_c_q;
  assign ram_rd_addr = dumping ? dump_issue_q[ADDR_W-1:0] : bin_c_q;

  fft_acc_ram #(
    .DEPTH  (FRAME_LEN),
    .ADDR_W (ADDR_W),
    .DATA_W (ACC_W)
  ) u_ram (
    .clk       (clk),
    .wr_en_i   (v_d_q),
    .wr_addr_i (bin_d_q),
    .wr_data_i (acc_new),
    .rd_en_i   (ram_rd_en),
    .rd_addr_i (ram_rd_addr),
    .rd_data_o (ram_rd_data)
  );

endmodule

// File: doc/fft_power_accum.md
# fft_power_accum

Downstream consumer of the FFT output FIFO in `fft_top`. It reads complete 512-bin frames from the FIFO (`dout`/`empty`/`dcount`/`rd_en` side) and computes per-bin power re²+im². It accumulates that power over a programmable number of frames in an on-chip RAM. When integration completes, it streams the integrated spectrum out over a valid/ready interface.

## Interface
Parameters:
- `FRAME_LEN`, 512: bins per FFT frame; power of two.
- `ADDR_W`, 9: log2(FRAME_LEN).
- `DATA_W`, 18: width of each signed FIFO component.
- `CNT_W`, 10: width of the FIFO `dcount`.
- `ACC_W`, 48: accumulator width, unsigned.

Ports:
- `clk` in 1: single clock for the whole block.
- `rst` in 1: synchronous, active-high reset.
- `fifo_dout` in 2*DATA_W: [35:18] = re, [17:0] = im, two's complement.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_dcount` in CNT_W: FIFO fill count.
- `fifo_rd_en` out 1: FIFO read strobe. The FIFO is standard (non-FWFT), so data is valid on the cycle after `fifo_rd_en`.
- `acc_len` in 16: frames per integration. 0 is treated as 1.
- `out_valid` out 1: spectrum word valid.
- `out_ready` in 1: downstream accept.
- `out_bin` out ADDR_W: bin index of `out_data`.
- `out_data` out ACC_W: integrated power.
- `out_last` out 1: asserted with bin FRAME_LEN-1.
- `busy` out 1: high in any state other than WAIT.
- `sat_flag` out 1: sticky accumulator saturation flag.

## Operation
FSM states:
- **WAIT**
  - `fifo_rd_en`=0.
  - Moves to READ when `fifo_dcount` ≥ FRAME_LEN-1. This matches the FIFO's frame-ready point.
  - `acc_len` is latched into `len_q` only when `frame_cnt`=0.
- **READ**
  - Asserts `fifo_rd_en` on each cycle that `fifo_empty`=0, until FRAME_LEN reads have been issued. `rd_cnt` counts from 0 to FRAME_LEN-1.
  - An empty FIFO mid-frame stalls issue: no read, and the bin address is held.
  - After the last read is issued, moves to DRAIN.
- **DRAIN**
  - Waits 4 cycles for the pipeline to empty, then increments `frame_cnt`.
  - If `frame_cnt`+1 == `len_q`: go to DUMP and clear `frame_cnt`.
  - Otherwise: go to WAIT.
- **DUMP**
  - Reads RAM bins 0..FRAME_LEN-1 in order and presents them on the out port.
  - Returns to WAIT after the handshake on which `out_last`=1 completes.
  - `fifo_rd_en`=0 throughout. The upstream FIFO keeps filling.

Datapath, for each read issued at cycle t:
- t+1: sample `fifo_dout`.
- t+2: registered re², im² (each 2*DATA_W bits, unsigned).
- t+3: registered sum p (2*DATA_W+1 = 37 bits); RAM read of the same bin issued.
- t+4: new = (`frame_cnt`==0) ? p : ram_rd + p; written to RAM.

Reads to consecutive bins never collide, because the write address always trails the read address by one cycle.

Arithmetic:
- -2^17 squared = 2^34 must be handled without overflow.
- Accumulation is unsigned, ACC_W bits, zero-extending p.

Reset:
- Clears to the WAIT state, `frame_cnt`=0, and all pipeline valids to 0.
- RAM is not cleared. The first frame of every integration overwrites it.

## Timing
- Reset values: `fifo_rd_en`=0, `out_valid`=0, `out_bin`=0, `out_data`=0, `out_last`=0, `busy`=0, `sat_flag`=0.
- WAIT→READ: the first `fifo_rd_en` occurs on the cycle after the dcount condition is seen.
- A full unstalled frame takes FRAME_LEN read cycles plus 4 drain cycles.
- DUMP:
  - First `out_valid` appears 2 cycles after DUMP entry.
  - Output is registered, with a one-deep skid so the RAM read latency is hidden.
  - Throughput is 1 word/cycle while `out_ready`=1.
  - `out_data`, `out_bin` and `out_last` hold stable while `out_valid`=1 and `out_ready`=0.
  - `out_valid` may not drop without a handshake.
- `rst` mid-READ or mid-DUMP:
  - Takes effect on the next edge.
  - Any partial frame already read is lost.
  - Any partial dump is discarded.

## Configuration
- `FFT_PWR_SAT_EN` defined:
  - Accumulation saturates at 2^ACC_W-1.
  - `sat_flag` is set on any saturating add and cleared only by `rst`.
- Not defined:
  - Accumulation wraps modulo 2^ACC_W.
  - `sat_flag` is tied to 0.

## Structure
- Shared package `fft_pkg`:
  - FRAME_LEN, ADDR_W, DATA_W and ACC_W constants.
  - FSM state enum (WAIT, READ, DRAIN, DUMP).
- Sub-module `fft_acc_ram`:
  - Simple dual-port RAM, FRAME_LEN × ACC_W.
  - One write port and one read port, with 1-cycle read latency.
  - Read of an address written on the same cycle returns old data; never exercised.

## Test plan
- **Single frame, acc_len=1:**
  - Stimulus: FIFO preloaded with 512 words, bin k = (re=k, im=1).
  - Required: exactly 512 `fifo_rd_en` pulses, then dump with `out_data`[k]=k²+1 and `out_last` at k=511.
- **Four frames, acc_len=4:**
  - Stimulus: four frames of constant (re=3, im=-4).
  - Required: every bin = 100; no dump occurs before the 4th frame.
- **Extreme values:**
  - Stimulus: re=im=-131072, acc_len=1.
  - Required: every bin = 2^35 with no sign error.
- **Stalls and backpressure:**
  - Stimulus: `fifo_empty` pulsed high for 3 cycles at bin 200; `out_ready` toggled 1-0-0-1 during the dump.
  - Required: no lost or duplicated bins; stalled output holds stable.
- **Reset mid-READ, then re-integration:**
  - Stimulus: `rst` asserted at bin 300 of frame 2 with acc_len=2; reset released and 2 fresh frames of (1,1) supplied.
  - Required: dump = 4 on every bin; no stale data appears.
- **Saturation, with `FFT_PWR_SAT_EN` and ACC_W=36:**
  - Stimulus: extreme values (re=im=-131072) over 2 frames.
  - Required: all bins = 2^36-1 and `sat_flag`=1.
  - Without the macro, the same stimulus must give 0 on all bins.
